// File: rtl/cache_pkg.sv
// Shared definitions for the blocking data cache: FSM encoding, bus widths
// and address-field geometry helpers.
package cache_pkg;

    localparam int ADDR_W            = 32;
    localparam int WORD_W            = 32;
    localparam int BYTE_OFF_BITS     = 2;
    localparam int CACHE_INDEX_BITS  = 4;
    localparam int CACHE_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } cache_state_e;

    function automatic int tag_bits(input int index_bits, input int offset_bits);
        return ADDR_W - index_bits - offset_bits - BYTE_OFF_BITS;
    endfunction

    function automatic int index_lsb(input int offset_bits);
        return BYTE_OFF_BITS + offset_bits;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped cache: valid/dirty bits (async-cleared),
// tags and data words, with one combinational read and independent writes.
module dcache_array
    import cache_pkg::*;
#(
    parameter int INDEX_BITS  = CACHE_INDEX_BITS,
    parameter int OFFSET_BITS = CACHE_OFFSET_BITS,
    parameter int TAG_BITS    = tag_bits(CACHE_INDEX_BITS, CACHE_OFFSET_BITS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [INDEX_BITS-1:0]  idx_i,
    input  logic [OFFSET_BITS-1:0] rd_off_i,
    output logic                   rd_valid_o,
    output logic                   rd_dirty_o,
    output logic [TAG_BITS-1:0]    rd_tag_o,
    output logic [WORD_W-1:0]      rd_word_o,
    input  logic                   word_we_i,
    input  logic [OFFSET_BITS-1:0] word_off_i,
    input  logic [WORD_W-1:0]      word_wdata_i,
    input  logic                   meta_we_i,
    input  logic                   meta_valid_i,
    input  logic                   meta_dirty_i,
    input  logic [TAG_BITS-1:0]    meta_tag_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [WORD_W-1:0]   data_q [LINES][WORDS];

    // Line state bits: cleared by reset so no stale or partial line survives it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we_i) begin
            valid_q[idx_i] <= meta_valid_i;
            dirty_q[idx_i] <= meta_dirty_i;
        end
    end

    // Tag store: contents are don't-care while the line is invalid.
    always_ff @(posedge clk_i) begin
        if (meta_we_i) begin
            tag_q[idx_i] <= meta_tag_i;
        end
    end

    // Data store: one word per cycle from a store hit or a refill beat.
    always_ff @(posedge clk_i) begin
        if (word_we_i) begin
            data_q[idx_i][word_off_i] <= word_wdata_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_word_o  = data_q[idx_i][rd_off_i];

endmodule

// File: rtl/dcache_blocking.sv
// Blocking direct-mapped write-back/write-allocate data cache: zero-latency
// hits, stall while a victim line is written back and the new line refilled.
module dcache_blocking
    import cache_pkg::*;
#(
    parameter int INDEX_BITS  = CACHE_INDEX_BITS,
    parameter int OFFSET_BITS = CACHE_OFFSET_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
    localparam int IDX_LSB  = index_lsb(OFFSET_BITS);
    localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;

    cache_state_e           state_q;
    logic [OFFSET_BITS-1:0] cnt_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic                   refilled_q;
    logic [31:0]            hit_count_q;
    logic [31:0]            miss_count_q;

    logic [OFFSET_BITS-1:0] cpu_off_s;
    logic [INDEX_BITS-1:0]  cpu_idx_s;
    logic [TAG_BITS-1:0]    cpu_tag_s;
    logic [OFFSET_BITS-1:0] rd_off_s;
    logic                   rd_valid_s;
    logic                   rd_dirty_s;
    logic [TAG_BITS-1:0]    rd_tag_s;
    logic [WORD_W-1:0]      rd_word_s;
    logic                   hit_s;
    logic                   miss_s;
    logic                   last_word_s;
    logic                   word_we_s;
    logic [OFFSET_BITS-1:0] word_off_s;
    logic [WORD_W-1:0]      word_wdata_s;
    logic                   meta_we_s;
    logic                   meta_dirty_s;
    logic                   unused_addr_s;

    assign cpu_off_s     = cpu_addr[IDX_LSB-1:BYTE_OFF_BITS];
    assign cpu_idx_s     = cpu_addr[IDX_LSB +: INDEX_BITS];
    assign cpu_tag_s     = cpu_addr[TAG_LSB +: TAG_BITS];
    assign unused_addr_s = ^cpu_addr[BYTE_OFF_BITS-1:0];

    // During write-back the read port walks the victim line; otherwise it serves the CPU word.
    assign rd_off_s    = (state_q == ST_WRITEBACK) ? cnt_q : cpu_off_s;
    assign hit_s       = cpu_req && (state_q == ST_IDLE) && rd_valid_s && (rd_tag_s == cpu_tag_s);
    assign miss_s      = cpu_req && (state_q == ST_IDLE) && !hit_s;
    assign last_word_s = (cnt_q == {OFFSET_BITS{1'b1}});

    dcache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_array (
        .clk_i        (clk),
        .rst_ni       (rst),
        .idx_i        (cpu_idx_s),
        .rd_off_i     (rd_off_s),
        .rd_valid_o   (rd_valid_s),
        .rd_dirty_o   (rd_dirty_s),
        .rd_tag_o     (rd_tag_s),
        .rd_word_o    (rd_word_s),
        .word_we_i    (word_we_s),
        .word_off_i   (word_off_s),
        .word_wdata_i (word_wdata_s),
        .meta_we_i    (meta_we_s),
        .meta_valid_i (1'b1),
        .meta_dirty_i (meta_dirty_s),
        .meta_tag_i   (cpu_tag_s)
    );

    // Array write controls: store hits and refill beats.
    always_comb begin
        word_we_s    = 1'b0;
        word_off_s   = cpu_off_s;
        word_wdata_s = cpu_wdata;
        meta_we_s    = 1'b0;
        meta_dirty_s = 1'b0;
        if (hit_s && cpu_we) begin
            word_we_s    = 1'b1;
            meta_we_s    = 1'b1;
            meta_dirty_s = 1'b1;
        end else if ((state_q == ST_REFILL) && mem_ack) begin
            word_we_s    = 1'b1;
            word_off_s   = cnt_q;
            word_wdata_s = mem_rdata;
            meta_we_s    = last_word_s;
        end else begin
            word_we_s = 1'b0;
        end
    end

    // CPU-facing outputs; gated by reset so an abandoned transfer releases the pipeline at once.
    always_comb begin
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        if (!rst) begin
            cpu_stall = 1'b0;
        end else begin
            cpu_stall = miss_s || (state_q != ST_IDLE);
            if (hit_s && !cpu_we) begin
                cpu_rdata = rd_word_s;
            end else begin
                cpu_rdata = '0;
            end
        end
    end

    // Memory bus address/data, held stable by the registered state and word counter.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_addr  = {rd_tag_s, cpu_idx_s, cnt_q, {BYTE_OFF_BITS{1'b0}}};
                mem_wdata = rd_word_s;
            end
            ST_REFILL: begin
                mem_addr  = {cpu_tag_s, cpu_idx_s, cnt_q, {BYTE_OFF_BITS{1'b0}}};
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    // Miss-handling FSM, word counter and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            refilled_q   <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (hit_s) begin
                        // The completion right after our own refill is not a real hit.
                        if (refilled_q) begin
                            refilled_q <= 1'b0;
                        end else begin
                            hit_count_q <= hit_count_q + 32'd1;
                        end
                    end else if (miss_s) begin
                        miss_count_q <= miss_count_q + 32'd1;
                        refilled_q   <= 1'b1;
                        mem_req_q    <= 1'b1;
                        if (rd_valid_s && rd_dirty_s) begin
                            state_q  <= ST_WRITEBACK;
                            mem_we_q <= 1'b1;
                        end else begin
                            state_q  <= ST_REFILL;
                            mem_we_q <= 1'b0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) begin
                        if (last_word_s) begin
                            cnt_q    <= '0;
                            state_q  <= ST_REFILL;
                            mem_we_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + OFFSET_BITS'(1);
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        if (last_word_s) begin
                            cnt_q     <= '0;
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + OFFSET_BITS'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_blocking.sv
// Directed self-checking bench for dcache_blocking with a word-serial memory
// model that supports a configurable number of wait cycles per transfer.
module tb_dcache_blocking;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_mis = 0;
    int mem_wait = 0;
    bit rand_ack = 1'b0;

    logic [31:0] mem_model [0:1023];
    logic [31:0] addr_q [$];
    logic        we_q   [$];
    logic [31:0] wd_q   [$];

    dcache_blocking dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: responds on the falling edge, logs every acknowledged beat.
    initial begin
        int          wait_cnt;
        logic [31:0] hold_addr;
        wait_cnt  = 0;
        hold_addr = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hC000_0000 | i;
        mem_model[32'h40 >> 2]  = 32'h11;
        mem_model[32'h44 >> 2]  = 32'h22;
        mem_model[32'h48 >> 2]  = 32'h33;
        mem_model[32'h4C >> 2]  = 32'h44;
        mem_model[32'h140 >> 2] = 32'h55;
        mem_model[32'h144 >> 2] = 32'h66;
        mem_model[32'h148 >> 2] = 32'h77;
        mem_model[32'h14C >> 2] = 32'h88;
        mem_model[32'h280 >> 2] = 32'hA0;
        mem_model[32'h284 >> 2] = 32'hA1;
        mem_model[32'h288 >> 2] = 32'hA2;
        mem_model[32'h28C >> 2] = 32'hA3;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) hold_addr = mem_addr;
                else check_eq("addr_hold", mem_addr, hold_addr);
                if (wait_cnt == mem_wait) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    addr_q.push_back(mem_addr);
                    we_q.push_back(mem_we);
                    wd_q.push_back(mem_wdata);
                    if (mem_we) mem_model[mem_addr[11:2]] = mem_wdata;
                    mem_rdata = mem_we ? 32'h0 : mem_model[mem_addr[11:2]];
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                mem_ack   = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = rand_ack ? 32'($urandom) : 32'h0;
            end
        end
    end

    task automatic clear_log();
        addr_q.delete();
        we_q.delete();
        wd_q.delete();
    endtask

    // One CPU access held until the stall drops; stall cycles counted at mid-cycle.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_stall,
                             input logic [31:0] exp_rdata);
        int n;
        clear_log();
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        n = 0;
        while (cpu_stall && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_stall"}, n, exp_stall);
        if (!we) check_eq({tag, "_rdata"}, cpu_rdata, exp_rdata);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic check_refill(input string tag, input int first, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            if (first + i < addr_q.size()) begin
                check_eq({tag, "_addr"}, addr_q[first+i], base + 32'(4 * i));
                check_eq({tag, "_we"}, 32'(we_q[first+i]), 32'h0);
            end else begin
                check_eq({tag, "_beats"}, addr_q.size(), first + i + 1);
            end
        end
    endtask

    initial begin
        logic [31:0] wb_exp [4];
        int n;
        wb_exp[0] = 32'h11;
        wb_exp[1] = 32'hDEADBEEF;
        wb_exp[2] = 32'h33;
        wb_exp[3] = 32'h44;
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", cpu_stall, 32'h0);
        check_eq("rst_mem_req", mem_req, 32'h0);
        check_eq("rst_mem_we", mem_we, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_rdata", cpu_rdata, 32'h0);
        check_eq("rst_hits", hit_count, 32'h0);
        check_eq("rst_misses", miss_count, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        do_access("miss40", 1'b0, 32'h40, 32'h0, 5, 32'h11);
        check_eq("miss40_beats", addr_q.size(), 4);
        check_refill("miss40", 0, 32'h40);
        check_eq("miss40_misses", miss_count, 32'd1);
        check_eq("miss40_hits", hit_count, 32'd0);

        do_access("hit48", 1'b0, 32'h48, 32'h0, 0, 32'h33);
        check_eq("hit48_beats", addr_q.size(), 0);
        check_eq("hit48_mem_req", mem_req, 32'h0);
        check_eq("hit48_hits", hit_count, 32'd1);

        do_access("st44", 1'b1, 32'h44, 32'hDEADBEEF, 0, 32'h0);
        check_eq("st44_hits", hit_count, 32'd2);

        do_access("dirty144", 1'b0, 32'h144, 32'h0, 9, 32'h66);
        check_eq("dirty144_beats", addr_q.size(), 8);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_q.size()) begin
                check_eq("wb_addr", addr_q[i], 32'h40 + 32'(4 * i));
                check_eq("wb_we", 32'(we_q[i]), 32'h1);
                check_eq("wb_data", wd_q[i], wb_exp[i]);
            end
        end
        check_refill("dirty144", 4, 32'h140);
        check_eq("dirty144_misses", miss_count, 32'd2);
        check_eq("dirty144_hits", hit_count, 32'd2);

        mem_wait = 3;
        do_access("slow288", 1'b0, 32'h288, 32'h0, 17, 32'hA2);
        check_eq("slow288_beats", addr_q.size(), 4);
        check_refill("slow288", 0, 32'h280);
        check_eq("slow288_misses", miss_count, 32'd3);

        // Reset in the middle of the second refill beat.
        clear_log();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h3C0;
        n = 0;
        while (addr_q.size() < 1 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("rst_mid_first_beat", addr_q.size(), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_mid_mem_req", mem_req, 32'h0);
        check_eq("rst_mid_stall", cpu_stall, 32'h0);
        check_eq("rst_mid_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mid_hits", hit_count, 32'h0);
        check_eq("rst_mid_misses", miss_count, 32'h0);
        cpu_req = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        mem_wait = 0;

        do_access("reload40", 1'b0, 32'h40, 32'h0, 5, 32'h11);
        check_eq("reload40_beats", addr_q.size(), 4);
        check_refill("reload40", 0, 32'h40);
        check_eq("reload40_misses", miss_count, 32'd1);
        check_eq("reload40_hits", hit_count, 32'd0);

        rand_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_eq("idle_mem_req", mem_req, 32'h0);
            check_eq("idle_stall", cpu_stall, 32'h0);
        end
        rand_ack = 1'b0;
        check_eq("idle_misses", miss_count, 32'd1);
        check_eq("idle_hits", hit_count, 32'd0);

        do_access("post_idle48", 1'b0, 32'h48, 32'h0, 0, 32'h33);
        check_eq("post_idle48_beats", addr_q.size(), 0);
        check_eq("post_idle48_hits", hit_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
